// File: rtl/dmem_responder_if.sv
// Request/response bundle between a pipeline EX/MEM stage (master) and the
// multi-cycle data memory responder (slave).
interface dmem_responder_if;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        ack_o;
    logic        err_o;

    modport master (
        output addr_i, wdata_i, MemRead_i, MemWrite_i,
        input  rdata_o, stall_o, ack_o, err_o
    );

    modport slave (
        input  addr_i, wdata_i, MemRead_i, MemWrite_i,
        output rdata_o, stall_o, ack_o, err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder: DEPTH x 32-bit word array behind a
// request/stall/ack handshake. A request accepted in IDLE stalls the pipeline
// for LATENCY cycles, then a single DONE cycle pulses ack_o.
// Optional macro DMEM_MISALIGN_CHECK_EN: misaligned accesses are suppressed
// and flagged on err_o during DONE; otherwise addr_i[1:0] is ignored.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    // Counter only has to hold LATENCY-2 (number of extra BUSY cycles)
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;

    // Request captured at the accept cycle
    logic [AW-1:0]   idx_reg;
    logic [31:0]     wdata_reg;
    logic            is_write_reg;
    logic            misalign_reg;

    logic [31:0]     mem [DEPTH];
    logic [31:0]     rdata_reg;
    logic            err_reg;

    logic            req;
    logic            in_misalign;
    logic [AW-1:0]   cur_idx;
    logic [31:0]     cur_wdata;
    logic            cur_write;
    logic            cur_misalign;
    logic            finish;
    logic            mem_we;
    logic            mem_re;
    logic            stall;
    logic            ack;

    // Upper address bits are deliberately ignored (addresses wrap)
    logic            unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.addr_i[31:AW+2], bus.addr_i[1:0]};

    assign req = bus.MemRead_i | bus.MemWrite_i;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign in_misalign = (bus.addr_i[1:0] != 2'b00);
`else
    assign in_misalign = 1'b0;
`endif

    // While IDLE the live inputs are the request (matters for LATENCY=1,
    // where the access completes on the accept edge itself); afterwards
    // the latched copy is used.
    assign cur_idx      = (state_reg == IDLE) ? bus.addr_i[AW+1:2] : idx_reg;
    assign cur_wdata    = (state_reg == IDLE) ? bus.wdata_i        : wdata_reg;
    assign cur_write    = (state_reg == IDLE) ? bus.MemWrite_i     : is_write_reg;
    assign cur_misalign = (state_reg == IDLE) ? in_misalign        : misalign_reg;

    // The array is touched only on the edge that enters DONE; a reset at
    // that edge aborts the access so an uncommitted write is lost.
    assign finish = (state_next == DONE) && !rst_i;
    assign mem_we = finish &&  cur_write && !cur_misalign;
    assign mem_re = finish && !cur_write && !cur_misalign;

    // State register and latency down-counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: IDLE accepts, BUSY counts down, DONE lasts one cycle
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                // Held request is ignored here; it is the one just served
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode: stall covers the accept cycle and all BUSY cycles
    always_comb begin
        stall = 1'b0;
        ack   = 1'b0;
        case (state_reg)
            IDLE:    stall = req;
            BUSY:    stall = 1'b1;
            DONE:    ack   = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Capture the request on the accept cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_reg      <= '0;
            wdata_reg    <= '0;
            is_write_reg <= 1'b0;
            misalign_reg <= 1'b0;
        end else if (state_reg == IDLE && req) begin
            idx_reg      <= bus.addr_i[AW+1:2];
            wdata_reg    <= bus.wdata_i;
            is_write_reg <= bus.MemWrite_i;   // write wins when both are set
            misalign_reg <= in_misalign;
        end
    end

    // Array write port; contents survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    // Registered read port; the value is held until the next read completes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_reg <= '0;
        end else if (mem_re) begin
            rdata_reg <= mem[cur_idx];
        end
    end

    // Misalignment flag, high only during the DONE cycle of a bad access
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= finish && cur_misalign;
        end
    end

    assign bus.rdata_o = rdata_reg;
    assign bus.stall_o = stall;
    assign bus.ack_o   = ack;
    assign bus.err_o   = err_reg;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words in the array (power of two, >= 4).
REQ-002 SHALL have parameter LATENCY, default 3, cycles from request accept to ack (>= 1).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port addr_i  input  32  byte address from the EX/MEM stage.
REQ-006 SHALL have port wdata_i  input  32  store data.
REQ-007 SHALL have port MemRead_i  input  1  load request.
REQ-008 SHALL have port MemWrite_i  input  1  store request.
REQ-009 SHALL have port rdata_o  output  32  load data; valid when ack_o is high after a read.
REQ-010 SHALL have port stall_o  output  1  pipeline freeze; the initiator holds all request inputs while it is high.
REQ-011 SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err_o  output  1  misaligned-access flag; see Configuration.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 SHALL accept a request in IDLE when MemRead_i or MemWrite_i is high; accept cycle = T; address, data and opcode latched at T.
REQ-015 SHALL drive stall_o high combinationally in cycle T, and high for cycles T..T+LATENCY-1 inclusive (LATENCY cycles total).
REQ-016 SHALL spend cycles T+1..T+LATENCY-1 in BUSY, driven by a down-counter; with LATENCY=1, IDLE goes directly to DONE.
REQ-017 SHALL occupy DONE in cycle T+LATENCY with ack_o=1 and stall_o=0, then return to IDLE.
REQ-018 SHALL ignore request inputs in DONE, because the same held request is still present; the next request is accepted from IDLE at T+LATENCY+1 at the earliest.
REQ-019 SHALL, for a read, present the array word on rdata_o in the DONE cycle and hold it until the next read ack.
REQ-020 SHALL, for a write, commit to the array at the edge ending cycle T+LATENCY-1, so the write is visible from T+LATENCY; rdata_o is unchanged.
REQ-021 SHALL treat MemRead_i and MemWrite_i both high as a write; the read is dropped.
REQ-022 SHALL form the word index from addr_i[log2(DEPTH)+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-023 SHALL keep ack_o low and stall_o low in IDLE when no request is present.

Reset
REQ-024 SHALL, on rst_i high at a rising edge, set state=IDLE, counter=0, rdata_o=0, ack_o=0 and err_o=0; stall_o then follows the IDLE rule.
REQ-025 SHALL abort an in-flight access on reset; a write not yet committed is discarded.
REQ-026 SHALL NOT reset array contents.

Configuration
REQ-027 SHALL support macro DMEM_MISALIGN_CHECK_EN.
REQ-028 With the macro defined: an accepted request with addr_i[1:0]!=0 performs no array access, keeps the normal stall/ack timing, and drives err_o=1 in the DONE cycle only; rdata_o is unchanged.
REQ-029 Without the macro: addr_i[1:0] is ignored and err_o is tied to 0.

Verification (DEPTH=256, LATENCY=3)
REQ-030 SHALL cover: write 0xDEADBEEF to 0x10 accepted at T -> stall_o high T..T+2, ack_o at T+3, rdata_o stays 0.
REQ-031 SHALL cover: then read 0x10 -> ack_o at T+3 with rdata_o=0xDEADBEEF, held until the next read ack.
REQ-032 SHALL cover: write 0x11111111 to 0x400, then read 0x0 -> rdata_o=0x11111111 (wrap).
REQ-033 SHALL cover: MemRead_i=MemWrite_i=1, addr 0x8, data 0xA5A5A5A5 -> rdata_o unchanged; a subsequent read of 0x8 returns 0xA5A5A5A5.
REQ-034 SHALL cover: write 0x5 to 0x20 with rst_i pulsed at T+1 -> next cycle state IDLE, ack_o=0, rdata_o=0; a read of 0x20 returns its prior value.
REQ-035 SHALL cover: read 0x13 -> with macro, err_o=1 at T+3 and rdata_o unchanged; without macro, returns word 0x10 and err_o=0.
